// File: rtl/pipe_pkg.sv
// Shared types for the 4-stage pipeline hazard controller.
// Opcodes, field positions, scoreboard entry and FSM state.
package pipe_pkg;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BR    = 2'b11;

  localparam int OP_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RS_LSB = 2;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [1:0] rd;
    logic       is_load;
    logic       is_br;
  } sb_entry_t;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  function automatic logic op_writes(input logic [1:0] op);
    return (op == OP_ALU) || (op == OP_LOAD);
  endfunction

  function automatic logic op_reads_rd(input logic [1:0] op);
    return (op == OP_ALU) || (op == OP_STORE);
  endfunction

  function automatic logic op_reads_rs(input logic [1:0] op);
    return op != OP_BR;
  endfunction

  function automatic logic sb_hit(
    input sb_entry_t  e,
    input logic [1:0] r
  );
    return e.valid && e.we && (e.rd == r);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the 4-stage 8-bit pipeline.
// Build option: PIPE_HAZARD_FWD_EN enables operand forwarding.
module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [7:0]             instr_id,
  input  logic                   branch_taken_ex,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_valid,
  output logic                   mem_valid,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [1:0]             wb_rd,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt
);

  import pipe_pkg::*;

  logic       id_valid;
  sb_entry_t  ex_q, mem_q, wb_q, ex_d;
  state_t     state;

  logic [1:0] op, id_rd, id_rs;
  logic       rd_rd, rs_rd;
  logic       hazard, flush, stall;

  assign op    = instr_id[OP_LSB +: 2];
  assign id_rd = instr_id[RD_LSB +: 2];
  assign id_rs = instr_id[RS_LSB +: 2];
  assign rd_rd = op_reads_rd(op);
  assign rs_rd = op_reads_rs(op);

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard = id_valid && ex_q.is_load &&
                  ((rd_rd && sb_hit(ex_q, id_rd)) ||
                   (rs_rd && sb_hit(ex_q, id_rs)));
`else
  // WB writes the register file this cycle, so only EX and MEM matter
  assign hazard = id_valid &&
                  ((rd_rd && (sb_hit(ex_q, id_rd) ||
                              sb_hit(mem_q, id_rd))) ||
                   (rs_rd && (sb_hit(ex_q, id_rs) ||
                              sb_hit(mem_q, id_rs))));
`endif

  assign flush = ex_q.valid && ex_q.is_br &&
                 branch_taken_ex && (state != S_FLUSH);
  assign stall = hazard && !flush;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    if (!rst) begin
      pc_en        = !stall;
      if_id_en     = !stall;
      if_id_flush  = flush;
      id_ex_bubble = stall || flush;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!(stall || flush)) begin
      ex_d.valid   = id_valid;
      ex_d.we      = op_writes(op);
      ex_d.rd      = id_rd;
      ex_d.is_load = (op == OP_LOAD);
      ex_d.is_br   = (op == OP_BR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      state    <= S_RESET;
    end else begin
      if (flush)
        id_valid <= 1'b0;
      else if (!stall)
        id_valid <= fetch_valid;
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      unique case (state)
        S_RESET: state <= S_RUN;
        S_FLUSH: state <= S_RUN;
        default:
          state <= flush ? S_FLUSH :
                   stall ? S_STALL : S_RUN;
      endcase
    end
  end

  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign wb_we     = wb_q.valid && wb_q.we;
  assign wb_rd     = wb_q.rd;

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] ex_rs_q;
  logic       ex_rd_rd_q, ex_rs_rd_q;

  always_ff @(posedge clk) begin
    if (rst || stall || flush) begin
      ex_rs_q    <= '0;
      ex_rd_rd_q <= 1'b0;
      ex_rs_rd_q <= 1'b0;
    end else begin
      ex_rs_q    <= id_rs;
      ex_rd_rd_q <= rd_rd;
      ex_rs_rd_q <= rs_rd;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [1:0] r,
    input sb_entry_t  m,
    input sb_entry_t  w
  );
    if (!used)        return 2'b00;
    if (sb_hit(m, r)) return 2'b01;
    if (sb_hit(w, r)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!rst && ex_q.valid) begin
      fwd_a_sel = fwd_sel(ex_rd_rd_q, ex_q.rd, mem_q, wb_q);
      fwd_b_sel = fwd_sel(ex_rs_rd_q, ex_rs_q, mem_q, wb_q);
    end
  end
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  logic unused_bits;
  assign unused_bits = ^{instr_id[1:0], ex_q.is_load,
                         mem_q.is_load, mem_q.is_br,
                         wb_q.is_load, wb_q.is_br};

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(STALL_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random-stimulus bench for pipe_hazard_ctrl against an
// instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int CW   = 4;
  localparam int NCYC = 4000;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0;
  logic [7:0]    instr_id = 8'h00;
  logic          branch_taken_ex = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic          ex_valid, mem_valid, wb_valid, wb_we;
  logic [1:0]    wb_rd, fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid     (fetch_valid),
    .instr_id        (instr_id),
    .branch_taken_ex (branch_taken_ex),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_valid        (ex_valid),
    .mem_valid       (mem_valid),
    .wb_valid        (wb_valid),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // slot 0=ID 1=EX 2=MEM 3=WB
  bit         m_v[4];
  logic [7:0] m_i[4];
  int         m_stall, m_flush;

  function automatic logic [1:0] f_op(input logic [7:0] i);
    return i[7:6];
  endfunction
  function automatic logic [1:0] f_rd(input logic [7:0] i);
    return i[5:4];
  endfunction
  function automatic logic [1:0] f_rs(input logic [7:0] i);
    return i[3:2];
  endfunction
  function automatic bit writes(input logic [7:0] i);
    return f_op(i) == 2'd0 || f_op(i) == 2'd1;
  endfunction
  function automatic bit reads_a(input logic [7:0] i);
    return f_op(i) == 2'd0 || f_op(i) == 2'd2;
  endfunction
  function automatic bit reads_b(input logic [7:0] i);
    return f_op(i) != 2'd3;
  endfunction

  // does consumer c read the register producer p writes
  function automatic bit dep(
    input logic [7:0] c,
    input logic [7:0] p
  );
    if (!writes(p)) return 0;
    return (reads_a(c) && f_rd(c) == f_rd(p)) ||
           (reads_b(c) && f_rs(c) == f_rd(p));
  endfunction

  function automatic logic [1:0] src_from(
    input bit         used,
    input logic [1:0] r
  );
    if (!m_v[1] || !used) return 2'd0;
    if (m_v[2] && writes(m_i[2]) && f_rd(m_i[2]) == r)
      return 2'd1;
    if (m_v[3] && writes(m_i[3]) && f_rd(m_i[3]) == r)
      return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    logic [7:0] prog[$];
    logic [7:0] cur_ins;
    bit         cur_fv, hz, fl, st;
    logic [1:0] ea, eb;
    int         rst_left;

    prog = '{8'h10, 8'h24, 8'h00, 8'h00,
             8'h70, 8'h0C, 8'h00, 8'h00,
             8'hC0, 8'h10, 8'h24, 8'h00};
    cur_ins  = prog.pop_front();
    cur_fv   = 1'b1;
    rst_left = 3;
    m_stall  = 0;
    m_flush  = 0;
    for (int s = 0; s < 4; s++) begin
      m_v[s] = 1'b0;
      m_i[s] = 8'h00;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check("ex_valid", 32'(ex_valid), 32'(m_v[1]));
      check("mem_valid", 32'(mem_valid), 32'(m_v[2]));
      check("wb_valid", 32'(wb_valid), 32'(m_v[3]));
      check("wb_we", 32'(wb_we),
            32'(m_v[3] && writes(m_i[3])));
      if (m_v[3] && writes(m_i[3]))
        check("wb_rd", 32'(wb_rd), 32'(f_rd(m_i[3])));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));

      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 299) == 0) rst_left = 3;
      end
      branch_taken_ex = 1'($urandom_range(0, 1));
      fetch_valid     = cur_fv;
      instr_id        = m_i[0];
      #1;

`ifdef PIPE_HAZARD_FWD_EN
      hz = m_v[0] && m_v[1] && f_op(m_i[1]) == 2'd1 &&
           dep(m_i[0], m_i[1]);
      ea = src_from(reads_a(m_i[1]), f_rd(m_i[1]));
      eb = src_from(reads_b(m_i[1]), f_rs(m_i[1]));
`else
      hz = m_v[0] && ((m_v[1] && dep(m_i[0], m_i[1])) ||
                      (m_v[2] && dep(m_i[0], m_i[2])));
      ea = 2'd0;
      eb = 2'd0;
`endif
      fl = m_v[1] && f_op(m_i[1]) == 2'd3 && branch_taken_ex;
      st = hz && !fl;

      if (rst) begin
        check("pc_en_rst", 32'(pc_en), 32'd0);
        check("if_id_en_rst", 32'(if_id_en), 32'd0);
        check("flush_rst", 32'(if_id_flush), 32'd1);
        check("bubble_rst", 32'(id_ex_bubble), 32'd1);
        check("fwd_a_rst", 32'(fwd_a_sel), 32'd0);
        check("fwd_b_rst", 32'(fwd_b_sel), 32'd0);
        for (int s = 0; s < 4; s++) m_v[s] = 1'b0;
        m_stall = 0;
        m_flush = 0;
      end else begin
        check("pc_en", 32'(pc_en), 32'(!st));
        check("if_id_en", 32'(if_id_en), 32'(!st));
        check("if_id_flush", 32'(if_id_flush), 32'(fl));
        check("id_ex_bubble", 32'(id_ex_bubble),
              32'(st || fl));
        check("fwd_a_sel", 32'(fwd_a_sel), 32'(ea));
        check("fwd_b_sel", 32'(fwd_b_sel), 32'(eb));

        m_v[3] = m_v[2]; m_i[3] = m_i[2];
        m_v[2] = m_v[1]; m_i[2] = m_i[1];
        if (st || fl) begin
          m_v[1] = 1'b0;
        end else begin
          m_v[1] = m_v[0];
          m_i[1] = m_i[0];
        end
        if (fl) begin
          m_v[0] = 1'b0;
        end else if (!st) begin
          m_v[0] = cur_fv;
          m_i[0] = cur_ins;
        end
        if (st && m_stall < CMAX) m_stall++;
        if (fl && m_flush < CMAX) m_flush++;
        if (!st) begin
          if (prog.size() > 0) begin
            cur_ins = prog.pop_front();
            cur_fv  = 1'b1;
          end else begin
            cur_ins = 8'($urandom());
            cur_fv  = $urandom_range(0, 9) < 8;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
